motor_encoder_model: RTL and testbench
======================================

Name: motor_encoder_model

Overview:
- Closed-loop plant emulator: the other end of the motor drive interface.
- Consumes the PWM, direction and enable outputs that the motor driver produces, and models motor speed as a first-order lag.
- Regenerates quadrature encoder pulses, so encoder_detection and the MicroBlaze control loop can be exercised on the bench or on the FPGA without a physical motor.
- Sits in test/HIL builds between motor_driver_top outputs and its motor_encoder_in.

Parameters:
PWM_PERIOD_FREQ_HZ, 10000, PWM period frequency; sets the duty measurement window.
CLOCK_FREQ_HZ, 100000000, clk frequency; PERIOD_CYCLES = CLOCK_FREQ_HZ / PWM_PERIOD_FREQ_HZ.
FILTER_SHIFT, 3, speed lag; each window speed moves by (target - speed) >>> FILTER_SHIFT.
GAIN_SHIFT, 4, NCO increment = |speed| << GAIN_SHIFT.
ACC_W, 32, NCO phase accumulator width.
CPR_EDGES, 1200, quadrature edges per revolution (index feature only).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
motor_pwm_in  in  1  PWM from motor driver (asynchronous to clk)
motor_en_in  in  1  driver enable (ENA/ENB)
motor_dir_ina  in  1  direction A from driver
motor_dir_inb  in  1  direction B from driver
encoder_a_out  out  1  quadrature channel A
encoder_b_out  out  1  quadrature channel B
index_out  out  1  once-per-rev index (ENC_INDEX_EN only)
duty_count_out  out  32  high cycles measured in last window
duty_valid_out  out  1  one-cycle strobe when duty_count_out updates
speed_out  out  32  signed modelled speed, units of duty counts

Behaviour:
- Reset (async, active-high): all outputs 0. Window counter, high-count accumulator, speed, NCO accumulator, quadrature state {A,B}=00 and position counter all cleared. Reset mid-operation aborts the window in progress; no partial duty is reported.
- Input sync: motor_pwm_in, motor_en_in, motor_dir_ina and motor_dir_inb each pass through 2-flop synchronisers (2-cycle latency).
- Duty window: free-running counter 0..PERIOD_CYCLES-1. Accumulate the synced PWM each cycle. On count == PERIOD_CYCLES-1:
  - duty_count_out <= acc + pwm_sync
  - acc <= 0
  - duty_valid_out = 1 for exactly that next cycle
- Duty range: duty_count_out saturates at PERIOD_CYCLES. All-high gives PERIOD_CYCLES; all-low gives 0.
- Target (sampled at window end, from synced values):
  - +duty if en & A & ~B
  - -duty if en & ~A & B
  - 0 otherwise (disabled, brake A=B, coast)
- Speed update, cycle after duty_valid_out: diff = target - speed (33-bit signed).
  - If |diff| < 2^FILTER_SHIFT, speed <= target (snap; guarantees convergence to 0).
  - Else speed <= speed + (diff >>> FILTER_SHIFT).
  - speed_out reflects the new value the same cycle it is registered.
- NCO: each cycle acc <= acc + inc, with inc = |speed| << GAIN_SHIFT, saturated to 2^ACC_W - 1. Carry-out on cycle n advances the quadrature state on cycle n+1. Maximum one step per clock.
- Quadrature FSM: 4 gray states.
  - speed > 0 (forward, A leads): 00 -> 10 -> 11 -> 01 -> 00.
  - speed < 0: reverse order.
  - speed == 0: no steps; state holds.
- Sign change of speed reverses stepping immediately; no glitch; outputs change one bit per step.
- encoder_a_out and encoder_b_out are registered directly from the state bits.

Optional Feature:
- Macro: MOTOR_ENCODER_MODEL_INDEX_EN.
- Defined:
  - Signed position counter mod CPR_EDGES: +1 per forward step, -1 per reverse step.
  - index_out = 1 while position == 0 and state == 00; exactly one edge-period wide per revolution in either direction.
- Undefined: counter absent; index_out tied 0.

Decomposition:
- Package motor_model_pkg:
  - PERIOD_CYCLES computation
  - quadrature state encodings QS_00/QS_10/QS_11/QS_01
  - next/prev-state functions
- Sub-module quad_step_gen: NCO, quadrature FSM and optional index. Inputs: signed speed. Outputs: A, B, index.
- Top: synchronisers, duty window, speed filter.

Test Plan:
- Reset mid-window, then release. Sim params: CLOCK_FREQ_HZ=1000000, PWM=10000, PERIOD_CYCLES=100, FILTER_SHIFT=2. Expect all outputs 0 and state 00; first duty_valid_out exactly 100 cycles after reset release.
- 50% PWM (50 high/50 low), en=1, A=1, B=0. Expect duty_count_out=50 each window. speed_out sequence 12, 21, 28, 33, ..., 47, then snaps to 50.
- Constant 100% PWM, GAIN_SHIFT=4, ACC_W=16. Expect inc=1600 and one quadrature step every 40 or 41 cycles in forward order 00,10,11,01.
- Steady speed 50, then A=0, B=1. Expect target -50; speed crosses 0 and goes negative; step order reverses on the first step after the sign change; no double-bit transitions.
- en=0 from speed 50. Expect speed decays to exactly 0 (snap) and encoder outputs freeze; duty_count_out still reports 50.
- With index feature enabled, CPR_EDGES=8, forward for 24 steps. Expect index_out high 3 times, 8 steps apart; reversing also yields an index at position 0.

Source files
------------

// File: rtl/motor_encoder_model_pkg.sv
// Shared types and helpers for the motor plant emulator: window length and quadrature state sequencing.
package motor_model_pkg;

    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_10 = 2'b10,
        QS_11 = 2'b11,
        QS_01 = 2'b01
    } quad_state_e;

    function automatic int unsigned period_cycles(input int unsigned clk_hz, input int unsigned pwm_hz);
        return clk_hz / pwm_hz;
    endfunction

    // Forward rotation: A leads B.
    function automatic quad_state_e qs_next(input quad_state_e s);
        case (s)
            QS_00:   return QS_10;
            QS_10:   return QS_11;
            QS_11:   return QS_01;
            default: return QS_00;
        endcase
    endfunction

    function automatic quad_state_e qs_prev(input quad_state_e s);
        case (s)
            QS_00:   return QS_01;
            QS_01:   return QS_11;
            QS_11:   return QS_10;
            default: return QS_00;
        endcase
    endfunction

endpackage

// File: rtl/motor_encoder_model_quad_step_gen.sv
// NCO-driven quadrature encoder generator with optional once-per-rev index.
// Index counter built only when MOTOR_ENCODER_MODEL_INDEX_EN is defined.
module quad_step_gen
    import motor_model_pkg::*;
#(
    parameter int unsigned GAIN_SHIFT = 4,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned CPR_EDGES  = 1200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] speed,
    output logic               enc_a,
    output logic               enc_b,
    output logic               index
);

    localparam logic [63:0] INC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    quad_state_e      state_q, state_d;
    logic [31:0]      speed_mag;
    logic [63:0]      inc_wide;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    always_comb begin
        speed_mag = speed[31] ? -speed : speed;
        inc_wide  = {32'd0, speed_mag} << GAIN_SHIFT;
        inc       = (inc_wide > INC_MAX) ? INC_MAX[ACC_W-1:0] : inc_wide[ACC_W-1:0];
        sum       = {1'b0, acc_q} + {1'b0, inc};
        acc_d     = sum[ACC_W-1:0];
        carry_d   = sum[ACC_W];
        state_d   = state_q;
        // Direction taken from the speed at step time, so a sign change reverses at once.
        if (carry_q) begin
            if (speed[31]) begin
                state_d = qs_prev(state_q);
            end else if (speed != '0) begin
                state_d = qs_next(state_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            state_q <= QS_00;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            state_q <= state_d;
        end
    end

    assign {enc_a, enc_b} = state_q;

`ifdef MOTOR_ENCODER_MODEL_INDEX_EN
    localparam int unsigned POS_W = (CPR_EDGES > 1) ? $clog2(CPR_EDGES) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CPR_EDGES - 1);

    logic             step_fwd, step_rev;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             index_q, index_d;

    assign step_fwd = carry_q && !speed[31] && (speed != '0);
    assign step_rev = carry_q && speed[31];

    always_comb begin
        pos_d   = pos_q;
        index_d = index_q;
        if (step_fwd) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else if (step_rev) begin
            pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        end
        // Index is re-evaluated per step so it spans exactly one edge period.
        if (step_fwd || step_rev) begin
            index_d = (pos_d == '0) && (state_d == QS_00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= '0;
            index_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            index_q <= index_d;
        end
    end

    assign index = index_q;
`else
    logic [31:0] cpr_unused;
    assign cpr_unused = 32'(CPR_EDGES);
    assign index      = 1'b0;
`endif

endmodule

// File: rtl/motor_encoder_model.sv
// Closed-loop motor plant emulator: measures driver PWM duty, filters it into a speed, regenerates quadrature.
// Optional index output enabled by MOTOR_ENCODER_MODEL_INDEX_EN.
module motor_encoder_model
    import motor_model_pkg::*;
#(
    parameter int unsigned PWM_PERIOD_FREQ_HZ = 10000,
    parameter int unsigned CLOCK_FREQ_HZ      = 100000000,
    parameter int unsigned FILTER_SHIFT       = 3,
    parameter int unsigned GAIN_SHIFT         = 4,
    parameter int unsigned ACC_W              = 32,
    parameter int unsigned CPR_EDGES          = 1200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        motor_pwm_in,
    input  logic        motor_en_in,
    input  logic        motor_dir_ina,
    input  logic        motor_dir_inb,
    output logic        encoder_a_out,
    output logic        encoder_b_out,
    output logic        index_out,
    output logic [31:0] duty_count_out,
    output logic        duty_valid_out,
    output logic [31:0] speed_out
);

    localparam int unsigned PERIOD_CYCLES = period_cycles(CLOCK_FREQ_HZ, PWM_PERIOD_FREQ_HZ);
    localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [31:0] DUTY_MAX = 32'(PERIOD_CYCLES);

    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic               pwm_s, en_s, ina_s, inb_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        acc_q, acc_d, acc_sum;
    logic [31:0]        duty_q, duty_d;
    logic               valid_q, valid_d;
    logic signed [31:0] target_q, target_d;
    logic signed [31:0] speed_q, speed_d;
    logic signed [32:0] diff, step;
    logic [32:0]        diff_mag;

    assign {pwm_s, en_s, ina_s, inb_s} = sync2_q;

    always_comb begin
        sync1_d = {motor_pwm_in, motor_en_in, motor_dir_ina, motor_dir_inb};
        sync2_d = sync1_q;

        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        acc_sum  = acc_q + {31'd0, pwm_s};
        acc_d    = acc_sum;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        target_d = target_q;
        if (cnt_q == CNT_LAST) begin
            acc_d   = '0;
            duty_d  = (acc_sum > DUTY_MAX) ? DUTY_MAX : acc_sum;
            valid_d = 1'b1;
            if (en_s && ina_s && !inb_s) begin
                target_d = $signed(duty_d);
            end else if (en_s && !ina_s && inb_s) begin
                target_d = -$signed(duty_d);
            end else begin
                target_d = '0;
            end
        end

        // Snap when the remaining error is below one filter step, otherwise the lag never settles.
        diff     = {target_q[31], target_q} - {speed_q[31], speed_q};
        diff_mag = diff[32] ? -diff : diff;
        step     = diff >>> FILTER_SHIFT;
        speed_d  = speed_q;
        if (valid_q) begin
            if (diff_mag < (33'd1 << FILTER_SHIFT)) begin
                speed_d = target_q;
            end else begin
                speed_d = speed_q + step[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            target_q <= '0;
            speed_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            target_q <= target_d;
            speed_q  <= speed_d;
        end
    end

    assign duty_count_out = duty_q;
    assign duty_valid_out = valid_q;
    assign speed_out      = speed_q;

    quad_step_gen #(
        .GAIN_SHIFT (GAIN_SHIFT),
        .ACC_W      (ACC_W),
        .CPR_EDGES  (CPR_EDGES)
    ) u_quad_step_gen (
        .clk   (clk),
        .rst   (reset),
        .speed (speed_q),
        .enc_a (encoder_a_out),
        .enc_b (encoder_b_out),
        .index (index_out)
    );

endmodule

// File: tb/tb_motor_encoder_model.sv
// Directed self-checking bench for motor_encoder_model (100-cycle window, FILTER_SHIFT=2, ACC_W=16).
module tb_motor_encoder_model;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               motor_pwm_in = 1'b0;
    logic               motor_en_in = 1'b0;
    logic               motor_dir_ina = 1'b0;
    logic               motor_dir_inb = 1'b0;
    logic               encoder_a_out, encoder_b_out, index_out;
    logic [31:0]        duty_count_out;
    logic               duty_valid_out;
    logic signed [31:0] speed_out;

    int checks = 0;
    int errors = 0;
    int unsigned pwm_high = 100;
    int unsigned gen_cnt = 0;
    logic [1:0] mon_prev = 2'b00;

    localparam int EXP_FWD[12]   = '{12, 21, 28, 33, 37, 40, 42, 44, 45, 46, 47, 50};
    localparam int EXP_DECAY[10] = '{37, 27, 20, 15, 11, 8, 6, 4, 3, 0};
    localparam int EXP_REV[3]    = '{25, 6, -8};

    motor_encoder_model #(
        .PWM_PERIOD_FREQ_HZ (10000),
        .CLOCK_FREQ_HZ      (1000000),
        .FILTER_SHIFT       (2),
        .GAIN_SHIFT         (4),
        .ACC_W              (16),
        .CPR_EDGES          (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .motor_pwm_in   (motor_pwm_in),
        .motor_en_in    (motor_en_in),
        .motor_dir_ina  (motor_dir_ina),
        .motor_dir_inb  (motor_dir_inb),
        .encoder_a_out  (encoder_a_out),
        .encoder_b_out  (encoder_b_out),
        .index_out      (index_out),
        .duty_count_out (duty_count_out),
        .duty_valid_out (duty_valid_out),
        .speed_out      (speed_out)
    );

    always #5 clk = ~clk;

    // Periodic PWM: any 100 consecutive samples at a fixed pwm_high contain exactly pwm_high ones.
    always @(negedge clk) begin
        motor_pwm_in = (gen_cnt < pwm_high);
        gen_cnt = (gen_cnt == 99) ? 0 : gen_cnt + 1;
    end

    always @(posedge clk) begin
        #1;
        if (!reset && ({encoder_a_out, encoder_b_out} != mon_prev)) begin
            checks++;
            if (({encoder_a_out, encoder_b_out} ^ mon_prev) == 2'b11) begin
                errors++;
                $display("FAIL quad_one_bit: got %b after %b, required single-bit change",
                         {encoder_a_out, encoder_b_out}, mon_prev);
            end
        end
        mon_prev = {encoder_a_out, encoder_b_out};
    end

    function automatic logic [1:0] fwd_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic wait_valid(input int unsigned limit);
        bit ok = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (duty_valid_out) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no duty_valid_out within %0d cycles", limit);
        end
    endtask

    task automatic wait_speed(input int target, input int unsigned limit);
        bit ok = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (speed_out == target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_speed: speed_out %0d, required %0d within %0d cycles", speed_out, target, limit);
        end
    endtask

    task automatic wait_step(input int unsigned limit, output logic [1:0] old_ab,
                             output logic [1:0] new_ab, output int unsigned n);
        old_ab = {encoder_a_out, encoder_b_out};
        new_ab = old_ab;
        n = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            n++;
            if ({encoder_a_out, encoder_b_out} != old_ab) begin
                new_ab = {encoder_a_out, encoder_b_out};
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_step: no encoder step within %0d cycles", limit);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({encoder_a_out, encoder_b_out, index_out, duty_valid_out} !== 4'b0000 ||
            duty_count_out !== 32'd0 || speed_out !== 32'sd0) begin
            errors++;
            $display("FAIL %s: a=%b b=%b idx=%b valid=%b duty=%0d speed=%0d, required all 0",
                     tag, encoder_a_out, encoder_b_out, index_out, duty_valid_out, duty_count_out, speed_out);
        end
    endtask

    task automatic test_reset();
        pwm_high = 100;
        motor_en_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_initial");
        reset = 1'b0;
        repeat (37) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_window");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k < 100 && duty_valid_out) begin
                checks++;
                errors++;
                $display("FAIL first_valid_early: valid at cycle %0d, required at 100", k);
            end
        end
        checks++;
        if (duty_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL first_valid: got %b at cycle 100, required 1", duty_valid_out);
        end
        // Synchroniser latency hides the first two high cycles of the first window.
        checks++;
        if (duty_count_out !== 32'd98) begin
            errors++;
            $display("FAIL first_duty: got %0d required 98", duty_count_out);
        end
        @(posedge clk); #1;
        checks++;
        if (duty_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got %b required 0", duty_valid_out);
        end
    endtask

    task automatic test_duty_speed();
        motor_en_in = 1'b0;
        pwm_high = 50;
        pulse_reset();
        wait_valid(150);
        wait_valid(150);
        motor_en_in = 1'b1;
        motor_dir_ina = 1'b1;
        motor_dir_inb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_valid(150);
            checks++;
            if (duty_count_out !== 32'd50) begin
                errors++;
                $display("FAIL duty50[%0d]: got %0d required 50", i, duty_count_out);
            end
            @(posedge clk); #1;
            checks++;
            if (speed_out !== EXP_FWD[i]) begin
                errors++;
                $display("FAIL speed_fwd[%0d]: got %0d required %0d", i, speed_out, EXP_FWD[i]);
            end
        end
    endtask

    task automatic test_disable();
        logic [1:0] held;
        motor_en_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_valid(150);
            checks++;
            if (duty_count_out !== 32'd50) begin
                errors++;
                $display("FAIL duty_disabled[%0d]: got %0d required 50", i, duty_count_out);
            end
            @(posedge clk); #1;
            checks++;
            if (speed_out !== EXP_DECAY[i]) begin
                errors++;
                $display("FAIL speed_decay[%0d]: got %0d required %0d", i, speed_out, EXP_DECAY[i]);
            end
        end
        held = {encoder_a_out, encoder_b_out};
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if ({encoder_a_out, encoder_b_out} !== held || speed_out !== 32'sd0) begin
            errors++;
            $display("FAIL freeze: ab=%b speed=%0d, required ab=%b speed=0",
                     {encoder_a_out, encoder_b_out}, speed_out, held);
        end
    endtask

    task automatic test_nco_forward();
        logic [1:0] o, nw;
        int unsigned n;
        pwm_high = 100;
        motor_en_in = 1'b1;
        motor_dir_ina = 1'b1;
        motor_dir_inb = 1'b0;
        wait_speed(100, 6000);
        wait_valid(150);
        checks++;
        if (duty_count_out !== 32'd100) begin
            errors++;
            $display("FAIL duty_full: got %0d required 100", duty_count_out);
        end
        wait_step(200, o, nw, n);
        for (int i = 0; i < 8; i++) begin
            wait_step(200, o, nw, n);
            checks++;
            if (n < 40 || n > 41) begin
                errors++;
                $display("FAIL step_interval[%0d]: got %0d cycles required 40 or 41", i, n);
            end
            checks++;
            if (nw !== fwd_of(o)) begin
                errors++;
                $display("FAIL fwd_order[%0d]: got %b after %b required %b", i, nw, o, fwd_of(o));
            end
        end
    endtask

    task automatic test_reverse();
        logic [1:0] o, nw;
        int unsigned n;
        pwm_high = 50;
        wait_speed(50, 6000);
        wait_valid(150);
        motor_dir_ina = 1'b0;
        motor_dir_inb = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(150);
            checks++;
            if (duty_count_out !== 32'd50) begin
                errors++;
                $display("FAIL duty_rev[%0d]: got %0d required 50", i, duty_count_out);
            end
            @(posedge clk); #1;
            checks++;
            if (speed_out !== EXP_REV[i]) begin
                errors++;
                $display("FAIL speed_rev[%0d]: got %0d required %0d", i, speed_out, EXP_REV[i]);
            end
        end
        wait_step(3000, o, nw, n);
        checks++;
        if (nw !== rev_of(o)) begin
            errors++;
            $display("FAIL first_rev_step: got %b after %b required %b", nw, o, rev_of(o));
        end
        wait_speed(-50, 3000);
        for (int i = 0; i < 4; i++) begin
            wait_step(300, o, nw, n);
            checks++;
            if (nw !== rev_of(o)) begin
                errors++;
                $display("FAIL rev_order[%0d]: got %b after %b required %b", i, nw, o, rev_of(o));
            end
        end
    endtask

`ifdef MOTOR_ENCODER_MODEL_INDEX_EN
    task automatic test_index();
        logic [1:0] o, nw;
        int unsigned n;
        int pos = 0;
        int fwd_steps = 0;
        int rev_steps = 0;
        int idx_fwd = 0;
        int idx_rev = 0;
        pwm_high = 100;
        motor_en_in = 1'b1;
        motor_dir_ina = 1'b1;
        motor_dir_inb = 1'b0;
        pulse_reset();
        checks++;
        if (index_out !== 1'b0) begin
            errors++;
            $display("FAIL index_reset: got %b required 0", index_out);
        end
        for (int i = 0; i < 300 && rev_steps < 12; i++) begin
            if (fwd_steps == 24) begin
                motor_dir_ina = 1'b0;
                motor_dir_inb = 1'b1;
            end
            wait_step(2000, o, nw, n);
            if (nw == fwd_of(o)) begin
                pos = (pos + 1) % 8;
                fwd_steps++;
            end else begin
                pos = (pos + 7) % 8;
                rev_steps++;
            end
            checks++;
            if (index_out !== (pos == 0)) begin
                errors++;
                $display("FAIL index_pos: got %b at model position %0d", index_out, pos);
            end
            if (index_out && fwd_steps <= 24 && rev_steps == 0) idx_fwd++;
            if (index_out && rev_steps > 0 && nw == rev_of(o)) idx_rev++;
        end
        checks++;
        if (idx_fwd != 3) begin
            errors++;
            $display("FAIL index_fwd_count: got %0d required 3", idx_fwd);
        end
        checks++;
        if (idx_rev < 1) begin
            errors++;
            $display("FAIL index_rev_count: got %0d required at least 1", idx_rev);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_duty_speed();
        test_disable();
        test_nco_forward();
        test_reverse();
`ifdef MOTOR_ENCODER_MODEL_INDEX_EN
        test_index();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
